// File: rtl/ps2_dir_scheduler.sv
// rtl/ps2_dir_scheduler.sv - PS/2 scancode to queued snake direction scheduler
// Optional macro PS2_ARROW_KEYS_EN enables extended arrow-key decode.
module ps2_dir_scheduler #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  input  logic                      tick,
  output logic                      up,
  output logic                      down,
  output logic                      left,
  output logic                      right,
  output logic                      dir_changed,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      drop
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_e;

  state_e          state_q, state_d;
  logic [1:0]      mem_q [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [CW-1:0]   count_q;
  logic [1:0]      dir_q;
  logic [3:0]      dir_oh_q;
  logic            dir_changed_q, drop_q;
  logic            press_vld;
  logic [1:0]      press_dir, ref_dir;
  logic            accept, pop, full, enq, drop_d;

  // Returns {valid, dir}; dir codes: 00 up, 01 down, 10 left, 11 right.
  function automatic logic [2:0] decode_base(input logic [7:0] b);
    case (b)
      8'h1D:   decode_base = 3'b100;
      8'h1B:   decode_base = 3'b101;
      8'h1C:   decode_base = 3'b110;
      8'h23:   decode_base = 3'b111;
      default: decode_base = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] decode_ext(input logic [7:0] b);
`ifdef PS2_ARROW_KEYS_EN
    case (b)
      8'h75:   decode_ext = 3'b100;
      8'h72:   decode_ext = 3'b101;
      8'h6B:   decode_ext = 3'b110;
      8'h74:   decode_ext = 3'b111;
      default: decode_ext = 3'b000;
    endcase
`else
    decode_ext = {1'b0, b[1:0] & 2'b00};
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    press_vld = 1'b0;
    press_dir = 2'b00;
    if (byte_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_data == 8'hF0)      state_d = S_BRK;
          else if (byte_data == 8'hE0) state_d = S_EXT;
          else {press_vld, press_dir} = decode_base(byte_data);
        end
        S_EXT: begin
          if (byte_data == 8'hF0) state_d = S_EXT_BRK;
          else begin
            state_d = S_IDLE;
            {press_vld, press_dir} = decode_ext(byte_data);
          end
        end
        S_BRK, S_EXT_BRK: state_d = S_IDLE;
        default:          state_d = S_IDLE;
      endcase
    end
  end

  // Presses are judged against the last queued direction so repeats and
  // reversals are filtered relative to what the snake will be doing then.
  assign tail_ptr = wr_ptr_q - PW'(1);
  assign ref_dir  = (count_q != '0) ? mem_q[tail_ptr] : dir_q;
  assign accept   = press_vld && (press_dir != ref_dir) &&
                    (press_dir != {ref_dir[1], ~ref_dir[0]});
  assign full     = (count_q == FULL_CNT);
  assign pop      = tick && (count_q != '0);
  assign enq      = accept && (!full || pop);
  assign drop_d   = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= press_dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dir_q         <= 2'b11;
      dir_oh_q      <= 4'b1000;
      dir_changed_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_changed_q <= pop;
      drop_q        <= drop_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        dir_q    <= mem_q[rd_ptr_q];
        dir_oh_q <= 4'b0001 << mem_q[rd_ptr_q];
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign up          = dir_oh_q[0];
  assign down        = dir_oh_q[1];
  assign left        = dir_oh_q[2];
  assign right       = dir_oh_q[3];
  assign dir_changed = dir_changed_q;
  assign drop        = drop_q;
  assign q_count     = count_q;

endmodule

// File: doc/ps2_dir_scheduler.md
PS2_DIR_SCHEDULER -- requirements
Module: ps2_dir_scheduler

Interface
REQ-001 Parameter QDEPTH, default 4, direction queue depth; legal values are 2, 4 and 8.
REQ-002 clk  input  1  system clock; every register SHALL be clocked on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 byte_valid  input  1  one-cycle strobe marking a new PS/2 scancode byte on byte_data.
REQ-005 byte_data  input  8  scancode byte; it is sampled only when byte_valid=1.
REQ-006 tick  input  1  one-cycle game-step strobe.
REQ-007 up, down, left, right  output  1 each  registered one-hot current direction.
REQ-008 dir_changed  output  1  one-cycle pulse when the current direction is updated.
REQ-009 q_count  output  $clog2(QDEPTH)+1  number of queue entries.
REQ-010 drop  output  1  one-cycle pulse when a press is discarded because the queue is full.

Function
REQ-011 Internal direction code SHALL be 2 bits: 00 up, 01 down, 10 left, 11 right; the opposite direction SHALL be the code with bit0 inverted.
REQ-012 The parser FSM SHALL have the states IDLE, BRK, EXT and EXT_BRK, and SHALL advance only on cycles where byte_valid=1.
REQ-013 IDLE transitions: 0xF0 goes to BRK; 0xE0 goes to EXT; any other byte is a make code, is decoded, and the FSM stays in IDLE.
REQ-014 BRK transitions: the next byte is discarded and the FSM goes to IDLE.
REQ-015 EXT transitions: 0xF0 goes to EXT_BRK; any other byte is an extended make code, is decoded, and the FSM goes to IDLE.
REQ-016 EXT_BRK transitions: the next byte is discarded and the FSM goes to IDLE.
REQ-017 Base make decode SHALL be 0x1D=up (W), 0x1B=down (S), 0x1C=left (A) and 0x23=right (D); all other codes SHALL be ignored.
REQ-018 The reference direction SHALL be the tail queue entry when q_count>0, otherwise the current direction.
REQ-019 A decoded press equal to the reference direction SHALL be discarded, which suppresses typematic repeats.
REQ-020 A decoded press opposite to the reference direction SHALL be discarded, which blocks reversal.
REQ-021 An accepted press SHALL be written to the queue tail on the clock edge after byte_valid; the queue is FIFO-ordered with wrap-around pointers.
REQ-022 On tick with q_count>0, the head entry SHALL be popped into the current direction and dir_changed=1 for the following cycle.
REQ-023 On tick with an empty queue, the direction SHALL hold and dir_changed SHALL stay 0.
REQ-024 If an enqueue and a tick pop occur in the same cycle, both SHALL take effect and q_count SHALL be unchanged.
REQ-025 If the queue is full, a tick is asserted and a press is accepted in the same cycle, the press SHALL be enqueued and drop SHALL stay 0.
REQ-026 If the queue is full, no tick is asserted and a press is accepted, the press SHALL be discarded, the queue is unchanged, and drop=1 for one cycle.
REQ-027 If the queue is empty, the reference check SHALL use the pre-tick current direction, even on a cycle where tick is asserted.
REQ-028 Exactly one of up, down, left and right SHALL be 1 at all times after reset.

Reset
REQ-029 While rst=1: FSM=IDLE, queue empty, q_count=0, right=1, up=down=left=0, dir_changed=0 and drop=0.
REQ-030 Asserting rst mid-sequence SHALL abandon any pending prefix (F0/E0) and all queued entries immediately; it SHALL not wait for a clock edge.
REQ-031 The first byte after rst is released SHALL be parsed from IDLE.

Configuration
REQ-032 With macro PS2_ARROW_KEYS_EN defined, extended make codes SHALL decode as 0xE0 0x75=up, 0xE0 0x72=down, 0xE0 0x6B=left and 0xE0 0x74=right, and other extended codes SHALL be ignored.
REQ-033 With PS2_ARROW_KEYS_EN undefined, the EXT and EXT_BRK states SHALL still sequence per REQ-015 and REQ-016, but every extended make code SHALL be ignored.

Verification
REQ-034 Reset, then bytes 0x1D (W), tick -> q_count 1 after the byte, then up=1, right=0, dir_changed pulse one cycle after tick.
REQ-035 From right, bytes 0x1C (A), then 0x1D,0x1D,0x1D -> A discarded as reversal (q_count 0); single up entry queued; repeats discarded (q_count stays 1).
REQ-036 Bytes 0x1D, 0xF0,0x1D, 0x1C -> break sequence produces no entry; queue holds up then left; two ticks yield up then left.
REQ-037 QDEPTH=4, alternate 0x1D,0x23 five times with no tick -> q_count 4, drop pulses on fifth accepted press; repeat with tick coincident with fifth press -> no drop, q_count 4.
REQ-038 With the macro defined, bytes 0xE0,0x75 then tick -> up=1; with it undefined, same stimulus -> right=1 and q_count 0.
REQ-039 Send 0xF0, assert rst mid-cycle, release, send 0x1D -> 0x1D is accepted as a make code (q_count 1).
